// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: oversampling edge/bit counters, per-bit strobes to the
// sampler/deserializer/checkers, frame acceptance and sticky error status.
module uart_rx_ctrl #(
   parameter int unsigned sampling_bits = 6,
   parameter int unsigned bit_cnt_w     = 4,
   parameter int unsigned frame_data    = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx_in,
   input  logic                     par_en,
   input  logic [sampling_bits-1:0] prescale,
   input  logic                     strt_glitch,
   input  logic                     par_err,
   input  logic                     stp_err,
   output logic [sampling_bits-1:0] edge_cnt,
   output logic [bit_cnt_w-1:0]     bit_cnt,
   output logic                     dat_samp_en,
   output logic                     strt_chk_en,
   output logic                     deser_en,
   output logic                     par_chk_en,
   output logic                     stp_chk_en,
   output logic                     data_valid,
   output logic                     par_err_flag,
   output logic                     stp_err_flag
);

   localparam int unsigned EW = sampling_bits;
   localparam int unsigned BW = bit_cnt_w;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_DONE
   } state_t;

   state_t        r_state;
   logic [EW-1:0] r_prescale;
   logic [EW-1:0] r_edge_cnt;
   logic [BW-1:0] r_bit_cnt;
   logic          r_dat_samp_en;
   logic          r_strt_chk_en;
   logic          r_deser_en;
   logic          r_par_chk_en;
   logic          r_stp_chk_en;
   logic          r_data_valid;
   logic          r_par_err_flag;
   logic          r_stp_err_flag;

   logic          w_last_edge;
   logic          w_pre_strobe;
   logic          w_last_data;

   // Strobes are registered, so they are armed one edge early (P-3) to show at P-2.
   assign w_last_edge  = (r_edge_cnt == r_prescale - EW'(1));
   assign w_pre_strobe = (r_edge_cnt == r_prescale - EW'(3));
   assign w_last_data  = (r_bit_cnt == BW'(frame_data));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= S_IDLE;
         r_prescale     <= '0;
         r_edge_cnt     <= '0;
         r_bit_cnt      <= '0;
         r_dat_samp_en  <= 1'b0;
         r_strt_chk_en  <= 1'b0;
         r_deser_en     <= 1'b0;
         r_par_chk_en   <= 1'b0;
         r_stp_chk_en   <= 1'b0;
         r_data_valid   <= 1'b0;
         r_par_err_flag <= 1'b0;
         r_stp_err_flag <= 1'b0;
      end else begin
         r_strt_chk_en <= 1'b0;
         r_deser_en    <= 1'b0;
         r_par_chk_en  <= 1'b0;
         r_stp_chk_en  <= 1'b0;
         r_data_valid  <= 1'b0;

         case (r_state)
            S_IDLE: begin
               r_edge_cnt <= '0;
               r_bit_cnt  <= '0;
               if (!rx_in) begin
                  r_state        <= S_START;
                  r_prescale     <= prescale;
                  r_par_err_flag <= 1'b0;
                  r_stp_err_flag <= 1'b0;
                  r_dat_samp_en  <= 1'b1;
               end
            end

            S_START, S_DATA, S_PARITY, S_STOP: begin
               if (!w_last_edge) begin
                  r_edge_cnt    <= r_edge_cnt + EW'(1);
                  r_strt_chk_en <= w_pre_strobe && (r_state == S_START);
                  r_deser_en    <= w_pre_strobe && (r_state == S_DATA);
                  r_par_chk_en  <= w_pre_strobe && (r_state == S_PARITY);
                  r_stp_chk_en  <= w_pre_strobe && (r_state == S_STOP);
               end else begin
                  r_edge_cnt <= '0;
                  r_bit_cnt  <= r_bit_cnt + BW'(1);
                  case (r_state)
                     S_START: begin
                        if (strt_glitch) begin
                           r_state       <= S_IDLE;
                           r_bit_cnt     <= '0;
                           r_dat_samp_en <= 1'b0;
                        end else begin
                           r_state <= S_DATA;
                        end
                     end
                     S_DATA: begin
                        if (w_last_data) begin
                           r_state <= par_en ? S_PARITY : S_STOP;
                        end
                     end
                     S_PARITY: begin
                        r_par_err_flag <= r_par_err_flag | par_err;
                        r_state        <= S_STOP;
                     end
                     S_STOP: begin
                        r_stp_err_flag <= stp_err;
                        r_data_valid   <= !(r_par_err_flag || stp_err);
                        r_state        <= S_DONE;
                        r_bit_cnt      <= '0;
                        r_dat_samp_en  <= 1'b0;
                     end
                     default: ;
                  endcase
               end
            end

            // A low line here is already edge 0 of the next start bit.
            S_DONE: begin
               r_bit_cnt <= '0;
               if (!rx_in) begin
                  r_state        <= S_START;
                  r_edge_cnt     <= EW'(1);
                  r_prescale     <= prescale;
                  r_par_err_flag <= 1'b0;
                  r_stp_err_flag <= 1'b0;
                  r_dat_samp_en  <= 1'b1;
               end else begin
                  r_state    <= S_IDLE;
                  r_edge_cnt <= '0;
               end
            end

            default: begin
               r_state       <= S_IDLE;
               r_edge_cnt    <= '0;
               r_bit_cnt     <= '0;
               r_dat_samp_en <= 1'b0;
            end
         endcase
      end
   end

   assign edge_cnt     = r_edge_cnt;
   assign bit_cnt      = r_bit_cnt;
   assign dat_samp_en  = r_dat_samp_en;
   assign strt_chk_en  = r_strt_chk_en;
   assign deser_en     = r_deser_en;
   assign par_chk_en   = r_par_chk_en;
   assign stp_chk_en   = r_stp_chk_en;
   assign data_valid   = r_data_valid;
   assign par_err_flag = r_par_err_flag;
   assign stp_err_flag = r_stp_err_flag;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: expected strobe/data_valid events are queued
// by the frame driver and checked by a negedge monitor.
module tb_uart_rx_ctrl;

   localparam int unsigned SB = 6;
   localparam int unsigned BW = 4;
   localparam int          FD = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          rx_in = 1'b1;
   logic          par_en = 1'b0;
   logic [SB-1:0] prescale = 6'd8;
   logic          strt_glitch = 1'b0;
   logic          par_err = 1'b0;
   logic          stp_err = 1'b0;
   logic [SB-1:0] edge_cnt;
   logic [BW-1:0] bit_cnt;
   logic          dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en;
   logic          data_valid, par_err_flag, stp_err_flag;

   uart_rx_ctrl #(.sampling_bits(SB), .bit_cnt_w(BW), .frame_data(FD)) dut (
      .clk(clk), .rst(rst), .rx_in(rx_in), .par_en(par_en), .prescale(prescale),
      .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
      .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
      .strt_chk_en(strt_chk_en), .deser_en(deser_en), .par_chk_en(par_chk_en),
      .stp_chk_en(stp_chk_en), .data_valid(data_valid),
      .par_err_flag(par_err_flag), .stp_err_flag(stp_err_flag)
   );

   always #5 clk = ~clk;

   // kind: 1 strt, 2 deser, 3 par, 4 stp, 5 data_valid
   typedef struct {
      int kind;
      int cyc;
      int e_edge;
      int e_bit;
   } exp_t;

   exp_t exp_q[$];
   int   dv_log[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   bit   wobble = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp_v);
      end
   endtask

   function automatic int all_outs();
      return int'({edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en,
                   stp_chk_en, data_valid, par_err_flag, stp_err_flag});
   endfunction

   // Monitor: any strobe or data_valid pops one expected event.
   always @(negedge clk) begin : mon
      int   k;
      exp_t e;
      k = strt_chk_en ? 1 : deser_en ? 2 : par_chk_en ? 3 : stp_chk_en ? 4 : data_valid ? 5 : 0;
      if (rst && k != 0) begin
         chk("onehot", $countones({strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid}), 1);
         if (exp_q.size() == 0) begin
            chk("unexpected_event", k, 0);
         end else begin
            e = exp_q.pop_front();
            chk("evt_kind", k, e.kind);
            chk("evt_cycle", cyc, e.cyc);
            if (k == 5) begin
               dv_log.push_back(cyc);
               chk("dv_flags", int'({par_err_flag, stp_err_flag}), 0);
               chk("dv_samp_en", int'(dat_samp_en), 0);
            end else begin
               chk("evt_edge", int'(edge_cnt), e.e_edge);
               chk("evt_bit", int'(bit_cnt), e.e_bit);
               chk("evt_samp_en", int'(dat_samp_en), 1);
            end
         end
      end
   end

   function automatic logic line_bit(input int b, input logic [7:0] data, input bit pe);
      if (b == 0) return 1'b0;
      if (b <= FD) return data[b-1];
      if (pe && b == FD + 1) return ^data;
      return 1'b1;
   endfunction

   task automatic idle(input int n);
      rx_in = 1'b1; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Drives one frame; returns in the DONE cycle (or the IDLE cycle after a glitch).
   task automatic send_frame(input int p, input bit pe, input logic [7:0] data,
                             input bit glitch, input bit perr, input bit serr,
                             input bit chained, input bit chain_next);
      int   base, nb, c_end, b;
      bit   perr_eff;
      exp_t e;
      perr_eff = perr && pe;
      prescale = SB'(p);
      par_en   = pe;
      if (chained) begin
         base = cyc;
      end else begin
         rx_in = 1'b0;
         base  = cyc + 1;
      end
      nb = glitch ? 1 : 10 + int'(pe);
      for (int i = 0; i < nb; i++) begin
         e.kind   = (i == 0) ? 1 : (i <= FD) ? 2 : (pe && i == FD + 1) ? 3 : 4;
         e.cyc    = base + i * p + p - 2;
         e.e_edge = p - 2;
         e.e_bit  = i;
         exp_q.push_back(e);
      end
      if (!glitch && !perr_eff && !serr) begin
         e.kind = 5; e.cyc = base + nb * p; e.e_edge = 0; e.e_bit = 0;
         exp_q.push_back(e);
      end
      c_end = base + (glitch ? p : nb * p);
      while (cyc < c_end) begin
         @(posedge clk); #1;
         b = (cyc - base) / p;
         if (cyc == c_end)  rx_in = !chain_next;
         else if (glitch)   rx_in = (cyc < base + 2) ? 1'b0 : 1'b1;
         else               rx_in = line_bit(b, data, pe);
         strt_glitch = glitch && (cyc == base + p - 1);
         par_err     = perr_eff && (cyc == base + (FD + 1) * p + p - 1);
         stp_err     = serr && !glitch && (cyc == c_end - 1);
         if (wobble && cyc == base + p) prescale = 6'd16;
         if (cyc == base + (chained ? 1 : 0)) begin
            chk("start_edge", int'(edge_cnt), chained ? 1 : 0);
            chk("start_bit", int'(bit_cnt), 0);
            chk("start_samp_en", int'(dat_samp_en), 1);
            chk("start_flags_clear", int'({par_err_flag, stp_err_flag}), 0);
         end
      end
      chk("par_err_flag", int'(par_err_flag), (!glitch && perr_eff) ? 1 : 0);
      chk("stp_err_flag", int'(stp_err_flag), (!glitch && serr) ? 1 : 0);
      if (glitch) begin
         chk("glitch_edge", int'(edge_cnt), 0);
         chk("glitch_samp_en", int'(dat_samp_en), 0);
      end
   endtask

   initial begin : stim
      int   base;
      exp_t e;
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("reset_outputs", all_outs(), 0);
      rst = 1'b1;
      idle(3);
      chk("idle_outputs", all_outs(), 0);

      // 8N1, P=8, 0xA5; prescale wiggled mid-frame must be ignored
      wobble = 1'b1;
      send_frame(8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      wobble = 1'b0;
      idle(5);

      // start glitch, P=16
      send_frame(16, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(40);

      // 8E1 parity error, then clean 8E1 frame clears the flag at start
      send_frame(8, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(3);
      send_frame(8, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(3);

      // stop error, 8N1, P=32
      send_frame(32, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(3);

      // parity and stop error together, 8E1, P=16
      send_frame(16, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(3);

      // back-to-back 8N1, P=8
      dv_log.delete();
      send_frame(8, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      send_frame(8, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(3);
      chk("b2b_dv_count", dv_log.size(), 2);
      if (dv_log.size() == 2) chk("b2b_dv_spacing", dv_log[1] - dv_log[0], 80);

      // reset during DATA bit 4, P=8
      prescale = 6'd8; par_en = 1'b0;
      rx_in = 1'b0;
      base = cyc + 1;
      for (int i = 0; i < 4; i++) begin
         e.kind = (i == 0) ? 1 : 2; e.cyc = base + i * 8 + 6; e.e_edge = 6; e.e_bit = i;
         exp_q.push_back(e);
      end
      while (cyc < base + 4 * 8 + 3) begin
         @(posedge clk); #1;
         rx_in = 1'b1;
      end
      chk("pre_reset_edge", int'(edge_cnt), 3);
      chk("pre_reset_bit", int'(bit_cnt), 4);
      rst = 1'b0;
      #1;
      chk("async_reset_outputs", all_outs(), 0);
      @(posedge clk); #1;
      chk("held_reset_outputs", all_outs(), 0);
      rst = 1'b1;
      idle(4);
      chk("post_reset_idle", all_outs(), 0);
      send_frame(8, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(10);

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

- Receive-side sequencer for the UART RX path.
- Owns the oversampling edge counter and the bit counter.
- Drives the enables of the data sampler, deserializer and the start, parity and stop checkers, and consumes their registered error flags.
- Decides per frame whether to raise `data_valid` and reports sticky per-frame parity and stop error status to the ALU-side logic.

## Interface
- `sampling_bits`, 6, width of `prescale` and `edge_cnt`
- `bit_cnt_w`, 4, width of `bit_cnt`
- `frame_data`, 8, data bits per frame
- `clk`  in  1  system/oversampling clock
- `rst`  in  1  asynchronous, active-low reset
- `rx_in`  in  1  synchronized serial line
- `par_en`  in  1  frame carries a parity bit
- `prescale`  in  sampling_bits  oversampling ratio; supported values 8, 16, 32
- `strt_glitch`  in  1  registered start-checker result
- `par_err`  in  1  registered parity-checker result
- `stp_err`  in  1  registered stop-checker result
- `edge_cnt`  out  sampling_bits  oversample edge index within the current bit
- `bit_cnt`  out  bit_cnt_w  bit index within the frame (start = 0)
- `dat_samp_en`  out  1  sampler enable
- `strt_chk_en`, `deser_en`, `par_chk_en`, `stp_chk_en`  out  1 each  one-cycle check/shift strobes
- `data_valid`  out  1  one-cycle pulse, frame accepted
- `par_err_flag`, `stp_err_flag`  out  1 each  sticky status of the last frame

## Operation
- States: IDLE, START, DATA, PARITY, STOP, DONE. All outputs reset to 0; state resets to IDLE.
- `prescale` is latched on IDLE→START. Changes mid-frame are ignored. Unsupported values are not checked.
- Edge counter: counts 0..P-1 in START/DATA/PARITY/STOP. At P-1 it wraps to 0 and `bit_cnt` increments. Both counters are held at 0 in IDLE.
- `dat_samp_en` is high in START, DATA, PARITY and STOP.
- Strobe rule: in each bit the state's strobe is asserted for exactly one cycle at `edge_cnt` = P-2. The checker flag is valid, and is evaluated, at `edge_cnt` = P-1.
- IDLE: on `rx_in`=0 go to START, clear both sticky flags, edge_cnt=0.
- START: strobe `strt_chk_en`. At P-1:
  - `strt_glitch`=1: go to IDLE with counters cleared, no further strobes.
  - otherwise: go to DATA.
- DATA: strobe `deser_en` once per bit. At P-1 of the bit with `bit_cnt`=frame_data, go to PARITY if `par_en`, else STOP.
- PARITY: strobe `par_chk_en`. At P-1, set `par_err_flag` |= `par_err` and go to STOP.
- STOP: strobe `stp_chk_en`. At P-1, set `stp_err_flag` = `stp_err` and go to DONE.
- DONE (one cycle):
  - `data_valid`=1 iff both flags are 0.
  - If `rx_in`=0, go directly to START with edge_cnt=1, so the DONE cycle counts as edge 0 of the new start bit. Else go to IDLE.
- Sticky flags hold until the next IDLE→START or DONE→START transition.
- `rst` asserted mid-frame: immediate return to IDLE, all outputs 0. No `data_valid` for the aborted frame.

## Timing
- Frame length F = 1 + frame_data + `par_en` + 1 bits.
- `data_valid` asserts exactly F·P + 1 clocks after the cycle in which IDLE first samples `rx_in`=0.
- Strobes are never asserted in IDLE or DONE. At most one strobe is high in any cycle.
- `bit_cnt` values:
  - 0 in START; 1..frame_data in DATA.
  - frame_data+1 in PARITY, or in STOP when no parity.
  - STOP with parity: frame_data+2.
- Error inputs are only read at `edge_cnt` = P-1 of the matching state. Values at other times are ignored.
- The `par_err` and `stp_err` checks in one frame are independent. Both flags may be set together.

## Test plan
- 8N1, P=8, byte 0xA5, checkers clean:
  - `deser_en` pulses exactly 8 times, at edge 6 of bits 1..8.
  - `data_valid` is a single pulse 81 clocks after the start edge.
  - Both flags are 0.
- Start glitch, P=16, `strt_glitch`=1 at edge 15 of START:
  - Return to IDLE; `deser_en`, `par_chk_en`, `stp_chk_en` never assert.
  - No `data_valid`.
- 8E1, P=8, `par_err`=1 at PARITY edge 7:
  - No `data_valid`; `par_err_flag`=1, `stp_err_flag`=0.
  - Flag clears on the next start edge.
- Stop error, 8N1, P=32, `stp_err`=1 at STOP edge 31:
  - No `data_valid`; `stp_err_flag`=1.
- Back-to-back 8N1 frames, P=8, second start bit immediately after the stop bit:
  - Two `data_valid` pulses spaced exactly 80 clocks apart.
  - Second frame enters START with edge_cnt=1.
- `rst` pulsed during DATA bit 4:
  - All outputs 0 and state IDLE in the same cycle.
  - The next clean frame completes normally.
